// File: rtl/bp_led_led_pio.sv
// Avalon-MM output PIO for board LEDs with optional global PWM dimming.
// Define LED_PIO_PWM_EN to build the duty register and PWM counter.
module bp_led_led_pio #(
  parameter int                    DATA_WIDTH  = 8,
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0,
  parameter int                    PRESCALE    = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [1:0]            address,
  input  logic                  chipselect,
  input  logic                  write_n,
  input  logic [31:0]           writedata,
  output logic [31:0]           readdata,
  output logic [DATA_WIDTH-1:0] out_port
);

  localparam logic [1:0] A_DATA = 2'd0;
  localparam logic [1:0] A_DUTY = 2'd1;
  localparam logic [1:0] A_SET  = 2'd2;
  localparam logic [1:0] A_CLR  = 2'd3;

  logic                  wr;
  logic [DATA_WIDTH-1:0] wd;
  logic [DATA_WIDTH-1:0] data;
  logic [7:0]            duty_rd;
  logic                  pwm_on;
  logic [31:0]           rd_next;
  logic                  unused_wd;

  assign wr = chipselect & ~write_n;
  assign wd = writedata[DATA_WIDTH-1:0];
  assign unused_wd = ^writedata;

  // data register: plain write, bit set, bit clear
  always_ff @(posedge clk) begin
    if (reset) begin
      data <= RESET_VALUE;
    end else if (wr) begin
      case (address)
        A_DATA:  data <= wd;
        A_SET:   data <= data | wd;
        A_CLR:   data <= data & ~wd;
        default: data <= data;
      endcase
    end
  end

`ifdef LED_PIO_PWM_EN
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [PW-1:0] prescaler;
  logic [7:0]    pwm_cnt;
  logic [7:0]    duty;
  logic [7:0]    duty_shadow;
  logic          wrap;

  assign wrap = (prescaler == PW'(PRESCALE - 1));

  // duty register, prescaler, PWM counter, period-aligned shadow
  always_ff @(posedge clk) begin
    if (reset) begin
      duty        <= 8'h00;
      duty_shadow <= 8'h00;
      prescaler   <= '0;
      pwm_cnt     <= 8'h00;
    end else begin
      if (wr && address == A_DUTY) begin
        duty <= writedata[7:0];
      end
      prescaler <= wrap ? '0 : prescaler + 1'b1;
      if (wrap) begin
        pwm_cnt <= pwm_cnt + 8'd1;
      end
      if (wrap && pwm_cnt == 8'hFF) begin
        duty_shadow <= duty;
      end
    end
  end

  assign pwm_on  = (pwm_cnt < duty_shadow);
  assign duty_rd = duty;
`else
  localparam int unused_prescale = PRESCALE;

  assign pwm_on  = 1'b1;
  assign duty_rd = 8'h00;
`endif

  // read mux, zero-extended
  always_comb begin
    rd_next = '0;
    case (address)
      A_DATA:  rd_next[DATA_WIDTH-1:0] = data;
      A_DUTY:  rd_next[7:0] = duty_rd;
      default: rd_next = '0;
    endcase
  end

  // registered read data and gated LED drive
  always_ff @(posedge clk) begin
    if (reset) begin
      readdata <= '0;
      out_port <= '0;
    end else begin
      readdata <= rd_next;
      out_port <= data & {DATA_WIDTH{pwm_on}};
    end
  end

endmodule

// File: tb/tb_bp_led_led_pio.sv
// Directed self-checking bench for bp_led_led_pio.
// PWM windows are checked when LED_PIO_PWM_EN is defined.
module tb_bp_led_led_pio;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [7:0]  out_port;

  int   errors = 0;
  int   checks = 0;
  logic [7:0] pc = 8'h00;
  bit   pwm;

  bp_led_led_pio #(
    .DATA_WIDTH (8),
    .RESET_VALUE(8'hA5),
    .PRESCALE   (1)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .address   (address),
    .chipselect(chipselect),
    .write_n   (write_n),
    .writedata (writedata),
    .readdata  (readdata),
    .out_port  (out_port)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (reset) pc = 8'h00;
    else pc = pc + 8'd1;
    #1;
  endtask

  task automatic wr(input logic [1:0] a,
                    input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    tick();
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = 32'h0;
  endtask

  task automatic rd(input logic [1:0] a);
    address = a;
    tick();
  endtask

  task automatic sync0();
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (pc != 8'h00 && n < 300);
  endtask

  task automatic win(input string tag,
                     input int duty,
                     input logic [7:0] dat);
    int bad;
    int ons;
    logic [7:0] exp;
    bad = 0;
    ons = 0;
    for (int i = 0; i < 256; i++) begin
      exp = (int'(pc) < duty) ? dat : 8'h00;
      tick();
      if (out_port !== exp) bad++;
      if (out_port === dat) ons++;
    end
    check({tag, "_shape"}, bad, 0);
    check({tag, "_on"}, ons,
          (duty > 255) ? 256 : duty);
  endtask

  initial begin
`ifdef LED_PIO_PWM_EN
    pwm = 1'b1;
`else
    pwm = 1'b0;
`endif
    reset      = 1'b1;
    address    = 2'd0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = 32'h0;
    tick();
    wr(2'd0, 32'hFF);
    tick();
    check("rst_rd", readdata, 32'h0);
    check("rst_out", {24'h0, out_port}, 32'h0);

    reset = 1'b0;
    rd(2'd0);
    check("rel_rd", readdata, 32'hA5);
    check("rel_out", {24'h0, out_port},
          pwm ? 32'h0 : 32'hA5);

    wr(2'd0, 32'h0F);
    wr(2'd2, 32'hC0);
    wr(2'd3, 32'h03);
    check("pre_out", {24'h0, out_port},
          pwm ? 32'h0 : 32'hCF);
    rd(2'd0);
    check("sc_rd", readdata, 32'hCC);
    check("sc_out", {24'h0, out_port},
          pwm ? 32'h0 : 32'hCC);

    wr(2'd2, 32'h0);
    wr(2'd3, 32'h0);
    rd(2'd0);
    check("zero_sc", readdata, 32'hCC);

    wr(2'd0, 32'h55);
    check("rw_old", readdata, 32'hCC);
    rd(2'd0);
    check("rw_new", readdata, 32'h55);

    rd(2'd2);
    check("rd2", readdata, 32'h0);
    rd(2'd3);
    check("rd3", readdata, 32'h0);

    wr(2'd0, 32'h1234_5633);
    rd(2'd0);
    check("hi_ign", readdata, 32'h33);

    wr(2'd1, 32'hABCD_0040);
    rd(2'd1);
    check("duty_rd", readdata,
          pwm ? 32'h40 : 32'h0);

`ifdef LED_PIO_PWM_EN
    wr(2'd0, 32'hFF);
    wr(2'd1, 32'd64);
    sync0();
    win("d64", 64, 8'hFF);
    wr(2'd1, 32'd0);
    sync0();
    win("d0", 0, 8'hFF);
    wr(2'd1, 32'd255);
    sync0();
    win("d255", 255, 8'hFF);

    wr(2'd1, 32'd64);
    sync0();
    begin
      int n;
      int ons;
      n = 0;
      while (pc != 8'd100 && n < 300) begin
        tick();
        n++;
      end
      wr(2'd1, 32'd192);
      ons = 0;
      n = 0;
      do begin
        tick();
        n++;
        if (out_port === 8'hFF) ons++;
      end while (pc != 8'h00 && n < 300);
      check("cur_per", ons, 0);
    end
    win("next192", 192, 8'hFF);

    wr(2'd1, 32'd128);
    sync0();
    for (int i = 0; i < 50; i++) tick();
    reset = 1'b1;
    tick();
    tick();
    check("mid_out", {24'h0, out_port}, 32'h0);
    check("mid_rd", readdata, 32'h0);
    reset = 1'b0;
    rd(2'd1);
    check("duty_rst", readdata, 32'h0);
    check("dark", {24'h0, out_port}, 32'h0);
    begin
      int n;
      int ons;
      ons = 0;
      n = 0;
      do begin
        tick();
        n++;
        if (out_port !== 8'h00) ons++;
      end while (pc != 8'h00 && n < 300);
      check("dark_per", ons, 0);
    end
    wr(2'd1, 32'd128);
    sync0();
    win("after_rst", 128, 8'hA5);
`else
    wr(2'd0, 32'hFF);
    win("nopwm", 256, 8'hFF);
`endif

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
